// File: rtl/gpu_conf_regs_if.sv
// OBI request/response channel bundles for the GPU configuration register block.
// Request carries the address phase plus grant; response carries the read data phase.
interface obi_req_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;

    modport master (output req, output we, output be, output addr, output wdata, input gnt);
    modport slave  (input req, input we, input be, input addr, input wdata, output gnt);
endinterface

interface obi_rsp_if;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (input rvalid, input rdata);
    modport slave  (output rvalid, output rdata);
endinterface

// File: rtl/gpu_conf_regs.sv
// GPU configuration/status registers on an OBI slave port, with a small
// IDLE/RUN/DONE kernel sequencer and a saturating kernel cycle counter.
module gpu_conf_regs #(
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned ADDR_DEC_BITS = 12
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    obi_req_if.slave conf_regs_req,
    obi_rsp_if.slave conf_regs_rsp,
    input  logic     cu_end_i,
    output logic     gpu_en_o,
    output logic     start_o,
    output logic     busy_o,
    output logic     irq_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [ADDR_DEC_BITS-1:0] OffCtrl   = ADDR_DEC_BITS'(32'h00);
    localparam logic [ADDR_DEC_BITS-1:0] OffStart  = ADDR_DEC_BITS'(32'h04);
    localparam logic [ADDR_DEC_BITS-1:0] OffStatus = ADDR_DEC_BITS'(32'h08);
    localparam logic [ADDR_DEC_BITS-1:0] OffCycles = ADDR_DEC_BITS'(32'h0C);
    localparam logic [ADDR_DEC_BITS-1:0] OffIrqEn  = ADDR_DEC_BITS'(32'h10);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cycles_q, cycles_d;
    logic                   ctrl_en_q, ctrl_en_d;
    logic                   irq_en_q, irq_en_d;
    logic                   start_q, start_d;
    logic                   rvalid_q;
    logic [31:0]            rdata_q, rdata_d;

    logic [ADDR_DEC_BITS-1:0] offset;
    logic                     wr_acc, rd_acc, be0;
    logic                     start_req, done_clr, en_clr;
    logic                     done, busy;
    logic [31:0]              rd_val;
    logic                     unused_bits;

    assign offset  = conf_regs_req.addr[ADDR_DEC_BITS-1:0];
    assign wr_acc  = conf_regs_req.req & conf_regs_req.we;
    assign rd_acc  = conf_regs_req.req & ~conf_regs_req.we;
    assign be0     = conf_regs_req.be[0];
    assign done    = (state_q == StDone);
    assign busy    = (state_q == StRun);

    assign start_req = wr_acc && offset == OffStart  && be0 && conf_regs_req.wdata[0];
    assign done_clr  = wr_acc && offset == OffStatus && be0 && conf_regs_req.wdata[1];
    assign en_clr    = wr_acc && offset == OffCtrl   && be0 && !conf_regs_req.wdata[0];

    assign unused_bits = ^{conf_regs_req.addr >> ADDR_DEC_BITS, conf_regs_req.be[3:1],
                           conf_regs_req.wdata[31:2]};

    // Every request is granted in the cycle it is presented.
    assign conf_regs_req.gnt = conf_regs_req.req;

    always_comb begin
        rd_val = '0;
        case (offset)
            OffCtrl:   rd_val = {31'b0, ctrl_en_q};
            OffStatus: rd_val = {30'b0, done, busy};
            OffCycles: rd_val = 32'(cycles_q);
            OffIrqEn:  rd_val = {31'b0, irq_en_q};
            default:   rd_val = '0;
        endcase
        rdata_d = rd_acc ? rd_val : '0;
    end

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        start_d   = 1'b0;
        ctrl_en_d = ctrl_en_q;
        irq_en_d  = irq_en_q;

        if (wr_acc && offset == OffCtrl && be0) begin
            ctrl_en_d = conf_regs_req.wdata[0];
        end
        if (wr_acc && offset == OffIrqEn && be0) begin
            irq_en_d = conf_regs_req.wdata[0];
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start_req && ctrl_en_q) begin
                    state_d  = StRun;
                    cycles_d = '0;
                    start_d  = 1'b1;
                end else if (state_q == StDone && done_clr) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                // Completion beats a simultaneous disable; counter freezes on either exit.
                if (cu_end_i) begin
                    state_d = StDone;
                end else if (en_clr) begin
                    state_d = StIdle;
                end else if (cycles_q != '1) begin
                    cycles_d = cycles_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cycles_q  <= '0;
            ctrl_en_q <= 1'b0;
            irq_en_q  <= 1'b0;
            start_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            ctrl_en_q <= ctrl_en_d;
            irq_en_q  <= irq_en_d;
            start_q   <= start_d;
            rvalid_q  <= conf_regs_req.req;
            rdata_q   <= rdata_d;
        end
    end

    assign conf_regs_rsp.rvalid = rvalid_q;
    assign conf_regs_rsp.rdata  = rdata_q;
    assign gpu_en_o             = ctrl_en_q;
    assign start_o              = start_q;
    assign busy_o               = busy;
    assign irq_o                = done & irq_en_q;

endmodule

// File: tb/tb_gpu_conf_regs.sv
// Bench for gpu_conf_regs: register vector tables plus kernel-sequencing scenarios,
// read data checked through an expected-response queue.
module tb_gpu_conf_regs;

    localparam int unsigned CNT_W   = 6;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 1);

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_en;
    } vec_t;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    logic cu_end = 1'b0;
    logic gpu_en, start, busy, irq;

    obi_req_if req_if ();
    obi_rsp_if rsp_if ();

    gpu_conf_regs #(
        .CNT_WIDTH     (CNT_W),
        .ADDR_DEC_BITS (12)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .conf_regs_req (req_if),
        .conf_regs_rsp (rsp_if),
        .cu_end_i      (cu_end),
        .gpu_en_o      (gpu_en),
        .start_o       (start),
        .busy_o        (busy),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          start_cnt = 0;
    int          s0;
    logic        req_seen;
    logic [31:0] exp_q[$];
    vec_t        tab_a[$];
    vec_t        tab_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request for exactly one acceptance edge; the expected response is queued now.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp);
        req_if.req   = 1'b1;
        req_if.we    = we;
        req_if.addr  = addr;
        req_if.wdata = wdata;
        req_if.be    = be;
        exp_q.push_back(we ? 32'h0 : exp);
        @(posedge clk);
        #1;
        req_if.req   = 1'b0;
        req_if.we    = 1'b0;
        req_if.addr  = '0;
        req_if.wdata = '0;
        req_if.be    = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        issue(1'b1, addr, data, 4'hf, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, addr, 32'h0, 4'hf, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) req_seen <= 1'b0;
        else         req_seen <= req_if.req;
    end

    // Response monitor: rvalid must follow each accepted request by exactly one cycle.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (start) start_cnt++;
            if (req_if.req || req_if.gnt) chk("gnt", 32'(req_if.gnt), 32'(req_if.req));
            if (rsp_if.rvalid || req_seen) begin
                chk("rvalid", 32'(rsp_if.rvalid), 32'(req_seen));
                if (rsp_if.rvalid) begin
                    if (exp_q.size() == 0) chk("rsp_queue_empty", 32'(exp_q.size()), 32'd1);
                    else                   chk("rdata", rsp_if.rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        req_if.req = 1'b0; req_if.we = 1'b0; req_if.addr = '0; req_if.wdata = '0; req_if.be = '0;

        //             we    addr         wdata        be    rdata  en
        tab_a.push_back('{1'b0, 32'h00,   32'h0,       4'hf, 32'h0, 1'b0});
        tab_a.push_back('{1'b0, 32'h08,   32'h0,       4'hf, 32'h0, 1'b0});
        tab_a.push_back('{1'b0, 32'h0C,   32'h0,       4'hf, 32'h0, 1'b0});
        tab_a.push_back('{1'b0, 32'h10,   32'h0,       4'hf, 32'h0, 1'b0});
        tab_a.push_back('{1'b1, 32'h10,   32'h1,       4'he, 32'h0, 1'b0});
        tab_a.push_back('{1'b0, 32'h10,   32'h0,       4'hf, 32'h0, 1'b0});
        tab_a.push_back('{1'b1, 32'h10,   32'h1,       4'h1, 32'h0, 1'b0});
        tab_a.push_back('{1'b0, 32'h10,   32'h0,       4'hf, 32'h1, 1'b0});
        tab_a.push_back('{1'b1, 32'h10,   32'h0,       4'hf, 32'h0, 1'b0});
        tab_a.push_back('{1'b1, 32'h00,   32'h1,       4'he, 32'h0, 1'b0});
        tab_a.push_back('{1'b0, 32'h00,   32'h0,       4'hf, 32'h0, 1'b0});
        tab_a.push_back('{1'b1, 32'h00,   32'hFFFFFFFF, 4'hf, 32'h0, 1'b1});
        tab_a.push_back('{1'b0, 32'h00,   32'h0,       4'hf, 32'h1, 1'b1});
        tab_a.push_back('{1'b1, 32'h14,   32'h5,       4'hf, 32'h0, 1'b1});
        tab_a.push_back('{1'b0, 32'h14,   32'h0,       4'hf, 32'h0, 1'b1});
        tab_a.push_back('{1'b0, 32'h04,   32'h0,       4'hf, 32'h0, 1'b1});
        tab_a.push_back('{1'b0, 32'h1000, 32'h0,       4'hf, 32'h1, 1'b1});
        tab_a.push_back('{1'b1, 32'h00,   32'h0,       4'hf, 32'h0, 1'b0});
        tab_a.push_back('{1'b0, 32'h00,   32'h0,       4'hf, 32'h0, 1'b0});

        tab_b.push_back('{1'b0, 32'h00,   32'h0,       4'hf, 32'h1, 1'b1});
        tab_b.push_back('{1'b0, 32'h14,   32'h0,       4'hf, 32'h0, 1'b1});
        tab_b.push_back('{1'b0, 32'h04,   32'h0,       4'hf, 32'h0, 1'b1});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpu_en", 32'(gpu_en), 32'd0);
        chk("rst_start",  32'(start),  32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_irq",    32'(irq),    32'd0);
        chk("rst_rvalid", 32'(rsp_if.rvalid), 32'd0);
        chk("rst_rdata",  rsp_if.rdata, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        tick(1);

        // Register access table, issued back to back
        for (int i = 0; i < tab_a.size(); i++) begin
            issue(tab_a[i].we, tab_a[i].addr, tab_a[i].wdata, tab_a[i].be, tab_a[i].exp_rdata);
            chk($sformatf("tab_a[%0d] gpu_en", i), 32'(gpu_en), 32'(tab_a[i].exp_en));
        end
        tick(1);

        // Start while disabled is ignored
        s0 = start_cnt;
        wr(32'h04, 32'h1);
        tick(3);
        chk("start_disabled_pulses", 32'(start_cnt - s0), 32'd0);
        chk("start_disabled_busy", 32'(busy), 32'd0);
        rd(32'h0C, 32'h0);
        rd(32'h08, 32'h0);

        // Enable, start, 20 counted cycles, completion
        wr(32'h00, 32'h1);
        chk("en_gpu_en", 32'(gpu_en), 32'd1);
        s0 = start_cnt;
        wr(32'h04, 32'h1);
        chk("start_pulse_hi", 32'(start), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        rd(32'h08, 32'h1);
        chk("start_pulse_lo", 32'(start), 32'd0);
        tick(19);
        cu_end = 1'b1;
        tick(1);
        cu_end = 1'b0;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_irq_masked", 32'(irq), 32'd0);
        chk("start_pulse_count", 32'(start_cnt - s0), 32'd1);
        rd(32'h08, 32'h2);
        rd(32'h0C, 32'd20);

        // Interrupt enable and W1C
        wr(32'h10, 32'h1);
        chk("irq_set", 32'(irq), 32'd1);
        wr(32'h08, 32'h2);
        chk("irq_clr", 32'(irq), 32'd0);
        chk("w1c_busy", 32'(busy), 32'd0);
        rd(32'h08, 32'h0);

        // W1C on the completion edge: set wins
        wr(32'h04, 32'h1);
        chk("restart_busy", 32'(busy), 32'd1);
        cu_end = 1'b1;
        wr(32'h08, 32'h2);
        cu_end = 1'b0;
        chk("set_wins_irq", 32'(irq), 32'd1);
        rd(32'h08, 32'h2);
        rd(32'h0C, 32'h0);
        cu_end = 1'b1;
        tick(2);
        cu_end = 1'b0;
        rd(32'h08, 32'h2);
        rd(32'h0C, 32'h0);

        // Restart from DONE, then a start while running is ignored
        s0 = start_cnt;
        wr(32'h04, 32'h1);
        rd(32'h08, 32'h1);
        chk("restart_irq", 32'(irq), 32'd0);
        wr(32'h04, 32'h1);
        rd(32'h0C, 32'h2);
        wr(32'h00, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_gpu_en", 32'(gpu_en), 32'd0);
        chk("run_start_ignored", 32'(start_cnt - s0), 32'd1);
        rd(32'h08, 32'h0);
        rd(32'h0C, 32'h3);

        // Completion and disable on the same edge
        wr(32'h00, 32'h1);
        wr(32'h04, 32'h1);
        cu_end = 1'b1;
        wr(32'h00, 32'h0);
        cu_end = 1'b0;
        chk("end_vs_dis_gpu_en", 32'(gpu_en), 32'd0);
        chk("end_vs_dis_busy", 32'(busy), 32'd0);
        rd(32'h08, 32'h2);
        rd(32'h0C, 32'h0);
        wr(32'h08, 32'h2);
        cu_end = 1'b1;
        tick(2);
        cu_end = 1'b0;
        rd(32'h08, 32'h0);

        // Counter saturation
        wr(32'h00, 32'h1);
        wr(32'h04, 32'h1);
        tick(80);
        cu_end = 1'b1;
        tick(1);
        cu_end = 1'b0;
        rd(32'h0C, CNT_MAX);

        // Back-to-back reads
        for (int i = 0; i < tab_b.size(); i++) begin
            issue(tab_b[i].we, tab_b[i].addr, tab_b[i].wdata, tab_b[i].be, tab_b[i].exp_rdata);
        end
        tick(1);

        // Reset mid-RUN with a response in flight and a request pending
        wr(32'h08, 32'h2);
        wr(32'h04, 32'h1);
        tick(3);
        rd(32'h08, 32'h1);
        chk("pre_rst_rvalid", 32'(rsp_if.rvalid), 32'd1);
        req_if.req  = 1'b1;
        req_if.we   = 1'b0;
        req_if.addr = 32'h0C;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_gpu_en", 32'(gpu_en), 32'd0);
        chk("async_start",  32'(start),  32'd0);
        chk("async_busy",   32'(busy),   32'd0);
        chk("async_irq",    32'(irq),    32'd0);
        chk("async_rvalid", 32'(rsp_if.rvalid), 32'd0);
        chk("async_rdata",  rsp_if.rdata, 32'd0);
        exp_q.delete();
        tick(2);
        req_if.req  = 1'b0;
        req_if.addr = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        tick(1);
        chk("post_rst_rvalid", 32'(rsp_if.rvalid), 32'd0);
        tick(2);
        rd(32'h00, 32'h0);
        rd(32'h08, 32'h0);
        chk("post_rst_gpu_en", 32'(gpu_en), 32'd0);

        tick(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpu_conf_regs.md
GPU_CONF_REGS -- requirements
Module: gpu_conf_regs

Interface
REQ-001 Parameter: CNT_WIDTH, default 32, width of the kernel cycle counter (max 32).
REQ-002 Parameter: ADDR_DEC_BITS, default 12, number of low address bits decoded; upper address bits are ignored.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 conf_regs_req  obi_req_if (slave side)  -  OBI request fields: req(1) in, we(1) in, be(4) in, addr(32) in, wdata(32) in, gnt(1) out.
REQ-006 conf_regs_rsp  obi_rsp_if (slave side)  -  OBI response fields: rvalid(1) out, rdata(32) out.
REQ-007 cu_end_i  input  1  compute-unit completion, level or pulse, sampled each cycle.
REQ-008 gpu_en_o  output  1  GPU enable, mirrors CTRL.EN.
REQ-009 start_o  output  1  one-cycle kernel start pulse to the controller.
REQ-010 busy_o  output  1  high while the FSM is in RUN.
REQ-011 irq_o  output  1  level interrupt = STATUS.DONE & IRQ_EN.EN.

Function
REQ-012 Register map (byte offsets, word aligned): 0x00 CTRL rw bit0 EN; 0x04 START wo; 0x08 STATUS bit0 BUSY ro, bit1 DONE W1C; 0x0C CYCLES ro; 0x10 IRQ_EN rw bit0 EN.
REQ-013 gnt shall equal req combinationally; every request is accepted in the cycle it is presented.
REQ-014 rvalid shall assert exactly one cycle after each accepted request, for one cycle; back-to-back requests yield back-to-back rvalid.
REQ-015 Read rdata shall be valid with rvalid and reflect register state at the acceptance edge; unused bits read 0.
REQ-016 Writes shall return rvalid with rdata = 0.
REQ-017 Unmapped offsets: writes ignored, reads return 0, rvalid still returned.
REQ-018 CTRL and IRQ_EN writes take effect only when be[0]=1.
REQ-019 A START write with be[0]=1 and wdata[0]=1 is a start request; START reads return 0.
REQ-020 FSM states: IDLE, RUN, DONE.
REQ-021 IDLE/DONE -> RUN on a start request while CTRL.EN=1; start_o pulses high for one cycle, the cycle after acceptance; CYCLES clears to 0 and DONE clears in the same edge.
REQ-022 Start requests while CTRL.EN=0 or in RUN are ignored (no pulse, no state change).
REQ-023 In RUN, CYCLES increments by 1 every cycle, saturating at all-ones (no wrap).
REQ-024 RUN -> DONE when cu_end_i=1; DONE sets on the same edge; CYCLES freezes.
REQ-025 RUN -> IDLE when CTRL.EN is written 0; CYCLES freezes; DONE is not set.
REQ-026 DONE -> IDLE when STATUS is written with wdata[1]=1 and be[0]=1; DONE clears.
REQ-027 cu_end_i in IDLE or DONE is ignored.
REQ-028 Simultaneous cu_end_i and DONE W1C write on the same edge: set wins (DONE=1).
REQ-029 Simultaneous cu_end_i and CTRL.EN=0 write in RUN: cu_end_i wins (-> DONE), EN still clears.
REQ-030 irq_o and busy_o are registered-state decodes, no combinational path from OBI inputs.

Reset
REQ-031 On rst_ni low, asynchronously: FSM=IDLE, CTRL.EN=0, IRQ_EN.EN=0, DONE=0, CYCLES=0, rvalid=0, rdata=0, start_o=0, gpu_en_o=0, busy_o=0, irq_o=0.
REQ-032 An OBI request in flight at reset is dropped; no rvalid after reset release for it.
REQ-033 First request after rst_ni rises is accepted normally on the next rising edge.

Verification
REQ-034 Write 0x00=1, write 0x04=1 -> gpu_en_o=1, start_o one-cycle pulse the cycle after START acceptance, busy_o=1, read 0x08 = 0x1.
REQ-035 Start, hold 20 cycles, pulse cu_end_i -> busy_o=0, read 0x08 = 0x2, read 0x0C = 20 (+/-0 per REQ-021/023 counting from the start edge).
REQ-036 Write 0x10=1 then complete a kernel -> irq_o=1; write 0x08=0x2 -> irq_o=0, FSM IDLE; same write on cu_end_i cycle -> DONE stays 1.
REQ-037 Write 0x04=1 with CTRL.EN=0, and again while busy -> no start_o pulse, CYCLES unchanged.
REQ-038 Back-to-back reads of 0x00, 0x14, 0x04 -> gnt each cycle, three consecutive rvalid, rdata 0x1, 0x0, 0x0.
REQ-039 Assert rst_ni=0 mid-RUN with a request pending -> all outputs 0 immediately, no stale rvalid after release.
